spram_arb_2p: RTL and testbench
===============================

// Module: spram_arb_2p
// PURPOSE
//  Two-requester controller for one single-port byte-enable SRAM (spram_byte_en macro).
//  Shares the SRAM between two strobe/ack ports with round-robin priority.
//  Sequences each access through a fixed 4-cycle schedule.
//  Optionally zero-fills the whole array after reset, before serving any request.
// PARAMETERS
//  ADDR_BITS       9   SRAM word-address width; DEPTH = 2**ADDR_BITS
//  DATA_BITS       32  data width; must be a multiple of 8
//  CLEAR_ON_RESET  1   1: zero-fill all DEPTH words after reset; 0: go straight to IDLE
// PORTS
//  clock       in   1             single clock; all logic on its rising edge
//  reset_n     in   1             asynchronous, active-low reset
//  pN_stb      in   1             N=0,1: request valid; held high until pN_ack
//  pN_we       in   1             1=write, 0=read
//  pN_adr      in   ADDR_BITS     word address
//  pN_dat_w    in   DATA_BITS     write data
//  pN_sel      in   DATA_BITS/8   byte enables (writes only)
//  pN_dat_r    out  DATA_BITS     read data; valid with pN_ack on reads
//  pN_ack      out  1             one-cycle completion pulse
//  sram_adr    out  ADDR_BITS     to SRAM a_adr
//  sram_dat_w  out  DATA_BITS     to SRAM a_dat_i
//  sram_we     out  1             to SRAM a_we
//  sram_sel    out  DATA_BITS/8   to SRAM a_sel
//  sram_dat_r  in   DATA_BITS     from SRAM a_dat_o; one-cycle synchronous read
//  init_busy   out  1             high while zero-fill is in progress
// BEHAVIOUR
//  Reset (async, reset_n=0):
//  - All outputs are 0, except init_busy=CLEAR_ON_RESET.
//  - State becomes CLEAR (or IDLE if CLEAR_ON_RESET=0); rr_ptr=0; clear counter=0.
//  - Reset mid-access aborts the access; no ack is issued; zero-fill restarts.
//  - All sram_* outputs are registered.
//  CLEAR: one word per cycle.
//  - sram_we=1, sram_sel=all ones, sram_dat_w=0, sram_adr=cnt.
//  - cnt counts 0..DEPTH-1; after word DEPTH-1 go to IDLE.
//  - init_busy falls on the cycle after the last write.
//  - Requests raised during CLEAR are held, not acked.
//  IDLE (cycle 0): sample pN_stb.
//  - Neither high: stay in IDLE.
//  - One high: grant that port.
//  - Both high: grant port rr_ptr, then set rr_ptr to the other port.
//  - A single-port grant sets rr_ptr to the non-granted port.
//  - Register the grant plus that port's adr/dat_w/we/sel onto sram_*; go to ACC.
//  ACC (cycle 1): SRAM sees the access and performs it at the end of cycle 1.
//  - On exit: sram_we<=0 and sram_sel<=0; go to CAP.
//  CAP (cycle 2): sram_dat_r is valid.
//  - Reads only: capture pG_dat_r <= sram_dat_r (G = granted port).
//  - Set pG_ack<=1; go to ACK.
//  ACK (cycle 3): pG_ack=1 for exactly this cycle; the requester drops stb next cycle.
//  - Strobes are not sampled in ACK, so a still-high stb on the granted port is not re-granted.
//  - Go to IDLE.
//  Timing and hold rules:
//  - Latency is stb seen in cycle 0 -> ack in cycle 3; peak throughput is 1 access per 4 cycles.
//  - pN_dat_r holds its last read value and is unchanged by writes and by the other port.
//  - The other port's stb may stay high throughout; it is served at the next IDLE.
//  - Input changes after grant (stb held, adr changed) have no effect on the in-flight access.
//  - Writes with sel=0 complete with ack and modify no bytes.
// TESTING
//  1 Reset with CLEAR_ON_RESET=1 -> init_busy high 512 cycles, sram_we=1 for adr 0..511 with dat 0;
//    then any read returns 0x00000000.
//  2 p0 write adr=0x1A5 dat=0xDEADBEEF sel=4'hF, then p0 read 0x1A5
//    -> ack 3 cycles after each stb sample, p0_dat_r=0xDEADBEEF.
//  3 Byte enables: write 0x11223344 sel=4'hF, then 0xAABBCCDD sel=4'b0101
//    -> readback 0x11BB33DD.
//  4 p0 and p1 stb held high continuously after reset -> grants alternate p0,p1,p0,p1;
//    each port acked every 8 cycles; no double ack.
//  5 p1 stb rises during CLEAR -> no ack until init_busy falls; first grant is p1 in the following IDLE.
//  6 reset_n low in ACC of a p0 write -> no p0_ack, all outputs 0, zero-fill restarts from adr 0.

Source files
------------

// File: rtl/spram_arb_2p.sv
// Two-port round-robin controller for one single-port byte-enable SRAM.
// Every access runs IDLE->ACC->CAP->ACK; optional zero-fill of the whole array after reset.

module spram_arb_2p_port #(
  parameter int DATA_BITS = 32
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 cap,
  input  logic                 rd,
  input  logic [DATA_BITS-1:0] sram_dat_r,
  output logic [DATA_BITS-1:0] dat_r,
  output logic                 ack
);
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      ack   <= 1'b0;
      dat_r <= '0;
    end else begin
      ack <= cap;
      if (cap && rd) dat_r <= sram_dat_r;
    end
  end
endmodule

module spram_arb_2p #(
  parameter int ADDR_BITS      = 9,
  parameter int DATA_BITS      = 32,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic                   p0_stb,
  input  logic                   p0_we,
  input  logic [ADDR_BITS-1:0]   p0_adr,
  input  logic [DATA_BITS-1:0]   p0_dat_w,
  input  logic [DATA_BITS/8-1:0] p0_sel,
  output logic [DATA_BITS-1:0]   p0_dat_r,
  output logic                   p0_ack,
  input  logic                   p1_stb,
  input  logic                   p1_we,
  input  logic [ADDR_BITS-1:0]   p1_adr,
  input  logic [DATA_BITS-1:0]   p1_dat_w,
  input  logic [DATA_BITS/8-1:0] p1_sel,
  output logic [DATA_BITS-1:0]   p1_dat_r,
  output logic                   p1_ack,
  output logic [ADDR_BITS-1:0]   sram_adr,
  output logic [DATA_BITS-1:0]   sram_dat_w,
  output logic                   sram_we,
  output logic [DATA_BITS/8-1:0] sram_sel,
  input  logic [DATA_BITS-1:0]   sram_dat_r,
  output logic                   init_busy
);
  localparam int SEL_BITS = DATA_BITS / 8;
  localparam int NP       = 2;

  typedef enum logic [2:0] {S_CLEAR, S_IDLE, S_ACC, S_CAP, S_ACK} state_t;

  state_t                        state;
  logic [ADDR_BITS-1:0]          cnt;
  logic                          rr_ptr, gnt, acc_we, pick;
  logic [NP-1:0]                 stb, we, ack;
  logic [NP-1:0][ADDR_BITS-1:0]  adr;
  logic [NP-1:0][DATA_BITS-1:0]  dat_w, dat_r;
  logic [NP-1:0][SEL_BITS-1:0]   sel;

  assign stb      = {p1_stb, p0_stb};
  assign we       = {p1_we, p0_we};
  assign adr      = {p1_adr, p0_adr};
  assign dat_w    = {p1_dat_w, p0_dat_w};
  assign sel      = {p1_sel, p0_sel};
  assign p0_dat_r = dat_r[0];
  assign p1_dat_r = dat_r[1];
  assign p0_ack   = ack[0];
  assign p1_ack   = ack[1];

  // Contention goes to rr_ptr; a lone requester wins regardless.
  assign pick = (stb[0] && stb[1]) ? rr_ptr : stb[1];

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state      <= (CLEAR_ON_RESET != 0) ? S_CLEAR : S_IDLE;
      cnt        <= '0;
      rr_ptr     <= 1'b0;
      gnt        <= 1'b0;
      acc_we     <= 1'b0;
      sram_adr   <= '0;
      sram_dat_w <= '0;
      sram_we    <= 1'b0;
      sram_sel   <= '0;
      init_busy  <= (CLEAR_ON_RESET != 0);
    end else begin
      case (state)
        S_CLEAR: begin
          sram_we    <= 1'b1;
          sram_sel   <= '1;
          sram_dat_w <= '0;
          sram_adr   <= cnt;
          if (cnt == '1) state <= S_IDLE;
          else           cnt   <= cnt + 1'b1;
        end
        S_IDLE: begin
          // The last zero-fill word is still on the bus during the first IDLE cycle.
          init_busy <= 1'b0;
          if (|stb) begin
            gnt        <= pick;
            rr_ptr     <= ~pick;
            acc_we     <= we[pick];
            sram_adr   <= adr[pick];
            sram_dat_w <= dat_w[pick];
            sram_we    <= we[pick];
            sram_sel   <= sel[pick];
            state      <= S_ACC;
          end else begin
            sram_we  <= 1'b0;
            sram_sel <= '0;
          end
        end
        S_ACC: begin
          sram_we  <= 1'b0;
          sram_sel <= '0;
          state    <= S_CAP;
        end
        S_CAP:   state <= S_ACK;
        S_ACK:   state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  for (genvar i = 0; i < NP; i++) begin : g_port
    spram_arb_2p_port #(.DATA_BITS(DATA_BITS)) u_port (
      .clock      (clock),
      .reset_n    (reset_n),
      .cap        (state == S_CAP && gnt == 1'(i)),
      .rd         (!acc_we),
      .sram_dat_r (sram_dat_r),
      .dat_r      (dat_r[i]),
      .ack        (ack[i])
    );
  end
endmodule

// File: tb/tb_spram_arb_2p.sv
// Bench for spram_arb_2p: SRAM model, directed vector table, corner sequences and
// randomized two-port traffic checked against a memory/latency-bound reference.

module tb_spram_arb_2p;
  localparam int AW = 9, DW = 32, SW = DW / 8, DEPTH = 1 << AW;

  logic clock = 1'b0, reset_n = 1'b0, scramble = 1'b0;
  logic [1:0]         stb = '0, we = '0;
  logic [1:0][AW-1:0] adr = '0;
  logic [1:0][DW-1:0] dat_w = '0;
  logic [1:0][SW-1:0] sel = '0;
  wire  [1:0][DW-1:0] dat_r;
  wire  [1:0]         ack;
  wire  [AW-1:0]      sram_adr;
  wire  [DW-1:0]      sram_dat_w;
  wire                sram_we;
  wire  [SW-1:0]      sram_sel;
  wire                init_busy;
  logic [DW-1:0]      sram_dat_r;

  logic [DW-1:0]      mem [DEPTH];
  logic [DW-1:0]      ref_mem [DEPTH];
  logic [1:0][DW-1:0] last_rd = '0;
  int total = 0, bad = 0;

  always #5 clock = ~clock;

  spram_arb_2p dut (
    .clock(clock), .reset_n(reset_n),
    .p0_stb(stb[0]), .p0_we(we[0]), .p0_adr(adr[0]), .p0_dat_w(dat_w[0]), .p0_sel(sel[0]),
    .p0_dat_r(dat_r[0]), .p0_ack(ack[0]),
    .p1_stb(stb[1]), .p1_we(we[1]), .p1_adr(adr[1]), .p1_dat_w(dat_w[1]), .p1_sel(sel[1]),
    .p1_dat_r(dat_r[1]), .p1_ack(ack[1]),
    .sram_adr(sram_adr), .sram_dat_w(sram_dat_w), .sram_we(sram_we), .sram_sel(sram_sel),
    .sram_dat_r(sram_dat_r), .init_busy(init_busy)
  );

  // Single-port byte-enable SRAM, one-cycle synchronous read; scramble fills it with junk.
  always @(posedge clock) begin
    if (scramble) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= $urandom;
    end else if (sram_we) begin
      for (int b = 0; b < SW; b++)
        if (sram_sel[b]) mem[sram_adr][b*8 +: 8] <= sram_dat_w[b*8 +: 8];
    end
    sram_dat_r <= mem[sram_adr];
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic apply_wr(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [SW-1:0] s);
    for (int b = 0; b < SW; b++) if (s[b]) ref_mem[a][b*8 +: 8] = d[b*8 +: 8];
  endtask

  task automatic do_reset();
    stb = '0;
    @(negedge clock);
    reset_n = 1'b0; scramble = 1'b1;
    repeat (2) @(negedge clock);
    scramble = 1'b0;
    chk("rst_sram_we", sram_we, 0);
    chk("rst_sram_adr", sram_adr, 0);
    chk("rst_sram_dat_w", sram_dat_w, 0);
    chk("rst_sram_sel", sram_sel, 0);
    chk("rst_ack", ack, 0);
    chk("rst_dat_r", dat_r, 0);
    chk("rst_init_busy", init_busy, 1);
    last_rd = '0;
    reset_n = 1'b1;
  endtask

  // Follows the zero-fill from reset release; optionally raises a p1 read part way through.
  task automatic run_clear(input int raise_at);
    int nwr, nbusy, nack, c;
    bit seq_ok;
    nwr = 0; nbusy = 0; nack = 0; c = 0; seq_ok = 1'b1;
    do begin
      @(negedge clock);
      if (init_busy) begin
        nbusy++;
        if (ack != 0) nack++;
        if (sram_we) begin
          if (sram_adr !== AW'(nwr) || sram_dat_w !== '0 || sram_sel !== '1) seq_ok = 1'b0;
          nwr++;
        end
      end
      if (c == raise_at) begin
        stb[1] = 1'b1; we[1] = 1'b0; adr[1] = 9'h1A5;
      end
      c++;
    end while (init_busy && c < 700);
    chk("clear_done", init_busy, 0);
    chk("clear_writes", nwr, DEPTH);
    chk("clear_busy_cycles", nbusy, DEPTH);
    chk("clear_sequence", seq_ok, 1);
    chk("clear_no_ack", nack, 0);
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
  endtask

  // One access started while the controller is idle; returns read data and ack latency.
  task automatic txn(input int p, input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d,
                     input logic [SW-1:0] s, output logic [DW-1:0] rd, output int lat);
    stb[p] = 1'b1; we[p] = w; adr[p] = a; dat_w[p] = d; sel[p] = s;
    lat = 0;
    do begin
      @(negedge clock);
      lat++;
    end while (!ack[p] && lat < 20);
    rd = dat_r[p];
    stb[p] = 1'b0;
    if (ack[p]) begin
      if (w) apply_wr(a, d, s);
      else   last_rd[p] = rd;
    end
    @(negedge clock);
    chk("single_ack", ack, 0);
  endtask

  typedef struct {
    int            p;
    logic          w;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    logic [SW-1:0] s;
    logic [DW-1:0] exp;
  } vec_t;

  vec_t vt[11];

  initial begin : main
    logic [DW-1:0] rd, other;
    int lat, k;
    int order[$], t0[$], t1[$];
    int dbl, age[2];
    bit pend[2], just[2];

    vt[0]  = '{0, 1'b0, 9'h1A5, 32'h0,        4'h0, 32'h0};
    vt[1]  = '{0, 1'b1, 9'h1A5, 32'hDEADBEEF, 4'hF, 32'h0};
    vt[2]  = '{0, 1'b0, 9'h1A5, 32'h0,        4'h0, 32'hDEADBEEF};
    vt[3]  = '{1, 1'b1, 9'h010, 32'h11223344, 4'hF, 32'h0};
    vt[4]  = '{1, 1'b1, 9'h010, 32'hAABBCCDD, 4'h5, 32'h0};
    vt[5]  = '{1, 1'b0, 9'h010, 32'h0,        4'h0, 32'h11BB33DD};
    vt[6]  = '{0, 1'b1, 9'h010, 32'hFFFFFFFF, 4'h0, 32'h0};
    vt[7]  = '{0, 1'b0, 9'h010, 32'h0,        4'h0, 32'h11BB33DD};
    vt[8]  = '{1, 1'b1, 9'h1FF, 32'hCAFEF00D, 4'hF, 32'h0};
    vt[9]  = '{1, 1'b0, 9'h1FF, 32'h0,        4'h0, 32'hCAFEF00D};
    vt[10] = '{0, 1'b0, 9'h000, 32'h0,        4'h0, 32'h0};

    // Reset, full zero-fill, then the directed vector table.
    do_reset();
    run_clear(-1);
    for (int i = 0; i < 11; i++) begin
      other = dat_r[1 - vt[i].p];
      rd = dat_r[vt[i].p];
      txn(vt[i].p, vt[i].w, vt[i].a, vt[i].d, vt[i].s, rd, lat);
      chk($sformatf("vec%0d_latency", i), lat, 3);
      chk($sformatf("vec%0d_dat_r", i), rd, vt[i].w ? last_rd[vt[i].p] : vt[i].exp);
      chk($sformatf("vec%0d_other_hold", i), dat_r[1 - vt[i].p], other);
    end

    // Inputs changed after the grant must not affect the in-flight write.
    stb[0] = 1'b1; we[0] = 1'b1; adr[0] = 9'h020; dat_w[0] = 32'h12345678; sel[0] = 4'hF;
    @(negedge clock);
    we[0] = 1'b0; adr[0] = 9'h021; dat_w[0] = 32'hFFFFFFFF; sel[0] = 4'h0;
    lat = 1;
    while (!ack[0] && lat < 20) begin
      @(negedge clock);
      lat++;
    end
    chk("late_change_latency", lat, 3);
    stb[0] = 1'b0;
    apply_wr(9'h020, 32'h12345678, 4'hF);
    @(negedge clock);
    txn(0, 1'b0, 9'h020, 32'h0, 4'h0, rd, lat);
    chk("late_change_kept", rd, 32'h12345678);
    txn(0, 1'b0, 9'h021, 32'h0, 4'h0, rd, lat);
    chk("late_change_other", rd, 32'h0);

    // Reset in the ACC cycle of a p0 write aborts it and restarts zero-fill.
    stb[0] = 1'b1; we[0] = 1'b1; adr[0] = 9'h033; dat_w[0] = 32'h5555AAAA; sel[0] = 4'hF;
    @(negedge clock);
    chk("acc_write_on_bus", {sram_we, sram_adr}, {1'b1, 9'h033});
    reset_n = 1'b0;
    #1;
    chk("abort_sram_zero", {sram_we, sram_sel, sram_adr, sram_dat_w}, 0);
    chk("abort_port_zero", {ack, dat_r}, 0);
    chk("abort_init_busy", init_busy, 1);
    stb[0] = 1'b0;
    @(negedge clock);
    chk("abort_no_ack", ack, 0);
    last_rd = '0;
    reset_n = 1'b1;
    run_clear(-1);
    txn(0, 1'b0, 9'h033, 32'h0, 4'h0, rd, lat);
    chk("abort_readback", rd, 32'h0);

    // p1 raised during zero-fill is served first in the following IDLE.
    do_reset();
    run_clear(100);
    k = 0;
    while (!ack[1] && !ack[0] && k < 10) begin
      @(negedge clock);
      k++;
    end
    chk("held_p1_ack_delay", k, 2);
    chk("held_p1_only", ack, 2'b10);
    chk("held_p1_data", dat_r[1], 32'h0);
    stb[1] = 1'b0;
    @(negedge clock);

    // Both ports held high from reset: strict alternation, 8-cycle period each.
    do_reset();
    stb = 2'b11; we = 2'b00; adr[0] = 9'h1A5; adr[1] = 9'h010;
    run_clear(-1);
    dbl = 0;
    for (int j = 1; j <= 40; j++) begin
      @(negedge clock);
      if (ack == 2'b11) dbl++;
      if (ack[0]) begin order.push_back(0); t0.push_back(j); end
      if (ack[1]) begin order.push_back(1); t1.push_back(j); end
    end
    chk("rr_no_double", dbl, 0);
    chk("rr_ack_count", order.size(), 10);
    if (order.size() >= 4)
      for (int i = 0; i < 4; i++) chk($sformatf("rr_order%0d", i), order[i], i % 2);
    if (t0.size() >= 2 && t1.size() >= 2) begin
      chk("rr_first_ack", t0[0], 2);
      chk("rr_p0_period", t0[1] - t0[0], 8);
      chk("rr_p1_period", t1[1] - t1[0], 8);
    end
    stb = '0;
    repeat (10) @(negedge clock);

    // Randomized traffic: memory semantics in ack order, bounded wait, data hold.
    pend = '{0, 0}; age = '{0, 0};
    for (int cyc = 0; cyc < 700; cyc++) begin
      @(negedge clock);
      just = '{0, 0};
      if (ack != 0) chk("rnd_one_ack", ack == 2'b11, 0);
      for (int p = 0; p < 2; p++) begin
        if (pend[p]) age[p]++;
        if (ack[p]) begin
          chk("rnd_ack_pending", pend[p], 1);
          if (pend[p]) begin
            chk("rnd_latency_bound", age[p] >= 3 && age[p] <= 8, 1);
            if (we[p]) begin
              apply_wr(adr[p], dat_w[p], sel[p]);
              chk("rnd_wr_hold", dat_r[p], last_rd[p]);
            end else begin
              chk("rnd_rd_data", dat_r[p], ref_mem[adr[p]]);
              last_rd[p] = dat_r[p];
            end
          end
          pend[p] = 1'b0; stb[p] = 1'b0; just[p] = 1'b1;
        end else begin
          chk("rnd_hold", dat_r[p], last_rd[p]);
          if (pend[p] && age[p] > 8) begin
            chk("rnd_timeout", age[p], 8);
            pend[p] = 1'b0; stb[p] = 1'b0;
          end
        end
        if (cyc < 680 && !pend[p] && !just[p] && $urandom_range(0, 2) == 0) begin
          stb[p] = 1'b1; we[p] = 1'($urandom_range(0, 1));
          adr[p] = AW'($urandom_range(0, 15)) | ($urandom_range(0, 1) != 0 ? 9'h1F0 : 9'h000);
          dat_w[p] = $urandom; sel[p] = SW'($urandom);
          pend[p] = 1'b1; age[p] = 0;
        end
      end
    end
    chk("rnd_drained", {pend[0], pend[1]}, 2'b00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end
endmodule
